// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: single-outstanding imem request/grant/response,
// IF/ID valid/ready presentation, and branch redirect with stale-response squash.
module fetch_ctrl #(
  parameter int                    ADDR_WITDH = 32,
  parameter int                    DATA_WITDH = 32,
  parameter logic [DATA_WITDH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WITDH-1:0] pc_in,
  output logic                  pc_en,
  output logic                  pc_taken,
  output logic [ADDR_WITDH-1:0] pc_target,
  input  logic                  redirect,
  input  logic [ADDR_WITDH-1:0] redirect_target,
  output logic                  imem_req,
  output logic [ADDR_WITDH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WITDH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WITDH-1:0] if_pc,
  output logic [DATA_WITDH-1:0] if_inst,
  input  logic                  id_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WITDH-1:0] addr_q, addr_d;
  logic                  valid_d;
  logic [ADDR_WITDH-1:0] pc_d;
  logic [DATA_WITDH-1:0] inst_d;

  // The memory only samples the address in the grant cycle, so it simply follows the PC.
  assign imem_addr = pc_in;
  assign pc_target = redirect_target;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    addr_d   = addr_q;
    valid_d  = if_valid;
    pc_d     = if_pc;
    inst_d   = if_inst;
    imem_req = 1'b0;
    pc_en    = redirect;
    pc_taken = redirect;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          pc_en   = 1'b1;
          addr_d  = pc_in;
          // A redirect in the grant cycle makes the granted fetch stale.
          kill_d  = redirect;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redirect) begin
            state_d = REQ;
          end else begin
            valid_d = 1'b1;
            pc_d    = addr_q;
            inst_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        if (id_ready || redirect) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // A redirect flushes whatever the IF/ID boundary would present next cycle.
    if (redirect) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      addr_q   <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      addr_q   <= addr_d;
      if_valid <= valid_d;
      if_pc    <= pc_d;
      if_inst  <= inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus a back-to-back throughput sequence.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DC  = 32'hFFFF_FFFF; // if_pc not checked

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en, pc_taken;
  logic [31:0] pc_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        id_ready;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_taken(pc_taken),
    .pc_target(pc_target), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_en;
    logic        e_taken;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] pc, input logic g, input logic rv,
                     input logic [31:0] rd, input logic rdy, input logic redir,
                     input logic [31:0] tgt, input logic e_req, input logic e_en,
                     input logic e_taken, input logic e_valid, input logic [31:0] e_pc,
                     input logic [31:0] e_inst);
    vec_t v;
    v.rst = r; v.pc = pc; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.rdy = rdy;
    v.redir = redir; v.tgt = tgt; v.e_req = e_req; v.e_en = e_en; v.e_taken = e_taken;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic redir,
                       input logic [31:0] tgt);
    rst = r; pc_in = pc; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    id_ready = rdy; redirect = redir; redirect_target = tgt;
  endtask

  initial begin
    logic [31:0] pc_model, pend, exp_pc;
    int          n_valid;

    // rst, pc, gnt, rvalid, rdata, rdy, redir, tgt | req, en, taken, valid, if_pc, if_inst
    // Basic fetch after reset, gnt/rvalid immediate
    add(1, 32'h0,   1, 1, 32'h00500093, 1, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h0,   1, 1, 32'h00500093, 1, 0, 0,       1, 1, 0, 0, DC, NOP);
    add(1, 32'h4,   1, 1, 32'h00500093, 1, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h4,   0, 0, 32'h0,        1, 0, 0,       0, 0, 0, 1, 32'h0, 32'h00500093);
    add(1, 32'h4,   1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    add(1, 32'h8,   0, 1, 32'hAAAA0001, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    // HOLD stall, with illegal gnt/rvalid that must be ignored
    for (int k = 0; k < 5; k++)
      add(1, 32'h8, 1, 1, 32'hBADBAD01, 0, 0, 0,       0, 0, 0, 1, 32'h4, 32'hAAAA0001);
    add(1, 32'h8,   0, 0, 32'h0,        1, 0, 0,       0, 0, 0, 1, 32'h4, 32'hAAAA0001);
    add(1, 32'h8,   1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    // Redirect in WAIT, stale response 3 cycles later
    add(1, 32'hC,   0, 0, 32'h0,        0, 1, 32'h100, 0, 1, 1, 0, DC, NOP);
    add(1, 32'h100, 0, 0, 32'h0,        0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h100, 0, 0, 32'h0,        0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h100, 0, 1, 32'hBBBB0002, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h100, 0, 0, 32'h0,        0, 0, 0,       1, 0, 0, 0, DC, NOP);
    add(1, 32'h100, 1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    add(1, 32'h104, 0, 1, 32'hCCCC0003, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h104, 0, 0, 32'h0,        1, 0, 0,       0, 0, 0, 1, 32'h100, 32'hCCCC0003);
    // Redirect together with gnt: granted fetch of 8 is killed
    add(1, 32'h8,   1, 0, 32'h0,        0, 1, 32'h40,  1, 1, 1, 0, DC, NOP);
    add(1, 32'h40,  0, 1, 32'hDDDD0004, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h40,  1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    // Redirect together with rvalid
    add(1, 32'h44,  0, 1, 32'hEEEE0005, 1, 1, 32'h200, 0, 1, 1, 0, DC, NOP);
    // gnt withheld 4 cycles
    for (int k = 0; k < 4; k++)
      add(1, 32'h200, 0, 0, 32'h0,      0, 0, 0,       1, 0, 0, 0, DC, NOP);
    add(1, 32'h200, 1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    // Reset in WAIT, then a late rvalid in IDLE and REQ
    add(0, 32'h204, 0, 0, 32'h0,        0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h204, 0, 1, 32'h99990006, 0, 0, 0,       0, 0, 0, 0, 32'h0, NOP);
    add(1, 32'h204, 0, 1, 32'h99990006, 0, 0, 0,       1, 0, 0, 0, DC, NOP);
    add(1, 32'h204, 1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    add(1, 32'h208, 0, 1, 32'hFFFF0007, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    // Redirect in HOLD with id_ready low drops the instruction
    add(1, 32'h208, 0, 0, 32'h0,        0, 1, 32'h300, 0, 1, 1, 1, 32'h204, 32'hFFFF0007);
    add(1, 32'h300, 0, 0, 32'h0,        0, 0, 0,       1, 0, 0, 0, DC, NOP);
    // Redirect in REQ without gnt
    add(1, 32'h300, 0, 0, 32'h0,        0, 1, 32'h500, 1, 1, 1, 0, DC, NOP);
    add(1, 32'h500, 1, 0, 32'h0,        0, 0, 0,       1, 1, 0, 0, DC, NOP);
    add(1, 32'h504, 0, 1, 32'h12340008, 0, 0, 0,       0, 0, 0, 0, DC, NOP);
    add(1, 32'h504, 0, 0, 32'h0,        1, 0, 0,       0, 0, 0, 1, 32'h500, 32'h12340008);

    // Reset state
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst.imem_req", {31'b0, imem_req}, 32'd0);
    check("rst.pc_en",    {31'b0, pc_en},    32'd0);
    check("rst.pc_taken", {31'b0, pc_taken}, 32'd0);
    check("rst.if_valid", {31'b0, if_valid}, 32'd0);
    check("rst.if_pc",    if_pc,             32'h0);
    check("rst.if_inst",  if_inst,           NOP);

    // Table
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.rst, v.pc, v.gnt, v.rvalid, v.rdata, v.rdy, v.redir, v.tgt);
      #1;
      check($sformatf("v%0d.imem_req", i), {31'b0, imem_req}, {31'b0, v.e_req});
      if (v.e_req) check($sformatf("v%0d.imem_addr", i), imem_addr, v.pc);
      check($sformatf("v%0d.pc_en", i),    {31'b0, pc_en},    {31'b0, v.e_en});
      check($sformatf("v%0d.pc_taken", i), {31'b0, pc_taken}, {31'b0, v.e_taken});
      if (v.e_taken) check($sformatf("v%0d.pc_target", i), pc_target, v.tgt);
      check($sformatf("v%0d.if_valid", i), {31'b0, if_valid}, {31'b0, v.e_valid});
      if (v.e_pc != DC) check($sformatf("v%0d.if_pc", i), if_pc, v.e_pc);
      check($sformatf("v%0d.if_inst", i), if_inst, v.e_inst);
    end

    // Back-to-back fetch with a modelled PC register and memory: one instruction per 3 cycles
    pc_model = 32'h504;
    pend     = 32'h0;
    exp_pc   = 32'h504;
    n_valid  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(1, pc_model, 1, 1, pend ^ 32'h5A5A_0000, 1, 0, 32'h0);
      #1;
      if (if_valid) begin
        check($sformatf("tp%0d.if_pc", c),   if_pc,   exp_pc);
        check($sformatf("tp%0d.if_inst", c), if_inst, exp_pc ^ 32'h5A5A_0000);
        exp_pc += 32'd4;
        n_valid++;
      end
      if (imem_req) pend = imem_addr;
      if (pc_en) pc_model += 32'd4;
    end
    check("tp.count", n_valid, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
